// File: rtl/wb_modport_device.sv
// wb_modport_device: Wishbone B4 classic device endpoint backed by a FIFO; writes push, reads pop.
module wb_modport_device #(
   parameter int DAT_WIDTH   = 8,
   parameter int DEPTH       = 4,
   parameter int WAIT_STATES = 0
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cyc_i,
   input  logic                 stb_i,
   input  logic                 we_i,
   input  logic [DAT_WIDTH-1:0] dat_i,
   output logic                 ack_o,
   output logic                 err_o,
   output logic                 rty_o,
   output logic [DAT_WIDTH-1:0] dat_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [3:0] WS = 4'(WAIT_STATES);
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [DAT_WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic req, rsp, full, empty, push, pop;
   assign req   = cyc_i && stb_i;
   assign full  = count_q == CW'(DEPTH);
   assign empty = count_q == '0;
   assign push  = ack_o && we_i;
   assign pop   = ack_o && !we_i;
   assign rty_o = 1'b0;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end
   // A dropped request anywhere in the wait sequence falls back to IDLE silently.
   always_comb begin
      state_d = IDLE;
      cnt_d   = cnt_q;
      if (WS != 4'd0 && req)
         unique case (state_q)
            IDLE: begin
               cnt_d   = 4'd1;
               state_d = (WS == 4'd1) ? RESP : WAIT;
            end
            WAIT: begin
               cnt_d   = cnt_q + 4'd1;
               state_d = (cnt_d == WS) ? RESP : WAIT;
            end
            default: state_d = IDLE;
         endcase
   end
   always_comb begin
      rsp   = !rst_i && req && (WS == 4'd0 || state_q == RESP);
      ack_o = rsp && (we_i ? !full : !empty);
      err_o = rsp && (we_i ? full : empty);
      dat_o = (rsp && !we_i && !empty) ? mem_q[rd_ptr_q] : '0;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (push) begin
         wr_ptr_q <= (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
         count_q  <= count_q + 1'b1;
      end else if (pop) begin
         rd_ptr_q <= (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
         count_q  <= count_q - 1'b1;
      end
   end
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= dat_i;
   end
endmodule

// File: tb/tb_wb_modport_device.sv
// tb_wb_modport_device: checks async-ack (0 wait) and sync-ack (3 wait) devices against a queue model.
module tb_wb_modport_device;
   localparam int DEPTH = 4;
   logic clk = 0, rst = 1;
   logic cyc0 = 0, stb0 = 0, we0 = 0, ack0, err0, rty0;
   logic cyc3 = 0, stb3 = 0, we3 = 0, ack3, err3, rty3;
   logic [7:0] di0 = 0, do0, di3 = 0, do3;
   int checks = 0, errors = 0;
   logic [7:0] q0[$], q3[$];
   logic ga, ge;
   logic [7:0] gr;
   logic [9:0] ex;
   int lat;

   always #5 clk = ~clk;

   wb_modport_device #(.DAT_WIDTH(8), .DEPTH(DEPTH), .WAIT_STATES(0)) u0 (
      .clk_i(clk), .rst_i(rst), .cyc_i(cyc0), .stb_i(stb0), .we_i(we0), .dat_i(di0),
      .ack_o(ack0), .err_o(err0), .rty_o(rty0), .dat_o(do0));
   wb_modport_device #(.DAT_WIDTH(8), .DEPTH(DEPTH), .WAIT_STATES(3)) u3 (
      .clk_i(clk), .rst_i(rst), .cyc_i(cyc3), .stb_i(stb3), .we_i(we3), .dat_i(di3),
      .ack_o(ack3), .err_o(err3), .rty_o(rty3), .dat_o(do3));

   // Expected {ack, err, dat} of one transfer; updates the FIFO contents model.
   function automatic void model(input bit s, input logic w, input logic [7:0] d, output logic [9:0] e);
      int n = s ? q3.size() : q0.size();
      e = '0;
      if (w) begin
         if (n == DEPTH) e[8] = 1'b1;
         else begin
            e[9] = 1'b1;
            if (s) q3.push_back(d); else q0.push_back(d);
         end
      end else if (n == 0) e[8] = 1'b1;
      else begin
         e[9] = 1'b1;
         e[7:0] = s ? q3.pop_front() : q0.pop_front();
      end
   endfunction

   task automatic go0(input logic w, input logic [7:0] d, output logic a, output logic e, output logic [7:0] r);
      @(posedge clk); #1 cyc0 = 1; stb0 = 1; we0 = w; di0 = d;
      @(negedge clk); a = ack0; e = err0; r = do0;
   endtask

   task automatic idle0;
      @(posedge clk); #1 cyc0 = 0; stb0 = 0; we0 = 0; di0 = 0;
   endtask

   task automatic go3(input logic w, input logic [7:0] d, output logic a, output logic e, output logic [7:0] r, output int l);
      @(posedge clk); #1 cyc3 = 1; stb3 = 1; we3 = w; di3 = d;
      a = 0; e = 0; r = 0; l = -1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (ack3 || err3) begin
            a = ack3; e = err3; r = do3; l = c;
            break;
         end
      end
      @(posedge clk); #1 cyc3 = 0; stb3 = 0; we3 = 0; di3 = 0;
   endtask

   task automatic test_reset;
      rst = 1;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      q0.delete(); q3.delete();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if ({ack0, err0, rty0, do0, ack3, err3, rty3, do3} !== 22'd0) begin
            errors++;
            $display("FAIL reset_idle cycle %0d: got a0=%b e0=%b r0=%b d0=%h a3=%b e3=%b r3=%b d3=%h want all 0",
                     i, ack0, err0, rty0, do0, ack3, err3, rty3, do3);
         end
      end
   endtask

   task automatic test_write_read;
      logic [7:0] wv[3] = '{8'hA5, 8'h00, 8'h00};
      logic ws[3] = '{1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 3; i++) begin
         go0(ws[i], wv[i], ga, ge, gr);
         model(0, ws[i], wv[i], ex);
         checks++;
         if ({ga, ge, gr} !== ex) begin
            errors++;
            $display("FAIL write_read step %0d: got ack=%b err=%b dat=%h want ack=%b err=%b dat=%h",
                     i, ga, ge, gr, ex[9], ex[8], ex[7:0]);
         end
      end
      checks++;
      if (ex !== {2'b01, 8'h00}) begin
         errors++;
         $display("FAIL write_read model_final: got %h want %h", ex, {2'b01, 8'h00});
      end
      idle0();
   endtask

   task automatic test_fill_overflow;
      for (int i = 1; i <= 5; i++) begin
         go0(1, 8'(i), ga, ge, gr);
         model(0, 1, 8'(i), ex);
         checks++;
         if ({ga, ge, gr} !== ex || ge !== (i == 5)) begin
            errors++;
            $display("FAIL fill write %0d: got ack=%b err=%b want ack=%b err=%b", i, ga, ge, ex[9], ex[8]);
         end
      end
      for (int i = 1; i <= 4; i++) begin
         go0(0, 8'h00, ga, ge, gr);
         model(0, 0, 8'h00, ex);
         checks++;
         if ({ga, ge, gr} !== ex || gr !== 8'(i)) begin
            errors++;
            $display("FAIL drain read %0d: got ack=%b err=%b dat=%h want ack=1 err=0 dat=%h", i, ga, ge, gr, 8'(i));
         end
      end
      idle0();
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 3; i++) begin
         go0(1, 8'h10 + 8'(i), ga, ge, gr);
         model(0, 1, 8'h10 + 8'(i), ex);
         checks++;
         if ({ga, ge, gr} !== ex) begin
            errors++;
            $display("FAIL b2b write %0d: got ack=%b err=%b want ack=%b err=%b", i, ga, ge, ex[9], ex[8]);
         end
      end
      for (int i = 0; i < 3; i++) begin
         go0(0, 8'h00, ga, ge, gr);
         model(0, 0, 8'h00, ex);
         checks++;
         if ({ga, ge, gr} !== ex || gr !== 8'h10 + 8'(i)) begin
            errors++;
            $display("FAIL b2b read %0d: got ack=%b err=%b dat=%h want ack=1 err=0 dat=%h", i, ga, ge, gr, 8'h10 + 8'(i));
         end
      end
      idle0();
   endtask

   task automatic test_random_async;
      for (int i = 0; i < 40; i++) begin
         logic w = 1'($urandom_range(0, 1));
         logic [7:0] d = 8'($urandom);
         go0(w, d, ga, ge, gr);
         model(0, w, d, ex);
         checks++;
         if ({ga, ge, gr} !== ex) begin
            errors++;
            $display("FAIL rand_async op %0d we=%b: got ack=%b err=%b dat=%h want ack=%b err=%b dat=%h",
                     i, w, ga, ge, gr, ex[9], ex[8], ex[7:0]);
         end
         if ($urandom_range(0, 3) == 0) idle0();
      end
      idle0();
   endtask

   task automatic test_wait_states;
      @(posedge clk); #1 cyc3 = 1; stb3 = 1; we3 = 1; di3 = 8'h33;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         checks++;
         if (ack3 !== (c == 3 || c == 7) || err3 !== 1'b0) begin
            errors++;
            $display("FAIL wait_timing T+%0d: got ack=%b err=%b want ack=%b err=0", c, ack3, err3, (c == 3 || c == 7));
         end
      end
      @(posedge clk); #1 cyc3 = 0; stb3 = 0; we3 = 0; di3 = 0;
      model(1, 1, 8'h33, ex);
      model(1, 1, 8'h33, ex);
      for (int i = 0; i < 3; i++) begin
         go3(0, 8'h00, ga, ge, gr, lat);
         model(1, 0, 8'h00, ex);
         checks++;
         if ({ga, ge, gr} !== ex || lat != 3) begin
            errors++;
            $display("FAIL wait_read %0d: got ack=%b err=%b dat=%h lat=%0d want ack=%b err=%b dat=%h lat=3",
                     i, ga, ge, gr, lat, ex[9], ex[8], ex[7:0]);
         end
      end
   endtask

   task automatic test_reset_mid;
      @(posedge clk); #1 cyc3 = 1; stb3 = 1; we3 = 1; di3 = 8'h77;
      @(negedge clk);
      @(posedge clk); #1 rst = 1;
      @(negedge clk);
      checks++;
      if (ack3 !== 1'b0 || err3 !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid during: got ack=%b err=%b want 0 0", ack3, err3);
      end
      @(posedge clk); #1 rst = 0; cyc3 = 0; stb3 = 0; we3 = 0; di3 = 0;
      q0.delete(); q3.delete();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (ack3 !== 1'b0 || err3 !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid after %0d: got ack=%b err=%b want 0 0", c, ack3, err3);
         end
      end
      go3(0, 8'h00, ga, ge, gr, lat);
      checks++;
      if ({ga, ge, gr} !== {2'b01, 8'h00} || lat != 3) begin
         errors++;
         $display("FAIL reset_mid read: got ack=%b err=%b dat=%h lat=%0d want ack=0 err=1 dat=00 lat=3", ga, ge, gr, lat);
      end
   endtask

   task automatic test_random_wait;
      for (int i = 0; i < 14; i++) begin
         logic w = 1'($urandom_range(0, 1));
         logic [7:0] d = 8'($urandom);
         go3(w, d, ga, ge, gr, lat);
         model(1, w, d, ex);
         checks++;
         if ({ga, ge, gr} !== ex || lat != 3) begin
            errors++;
            $display("FAIL rand_wait op %0d we=%b: got ack=%b err=%b dat=%h lat=%0d want ack=%b err=%b dat=%h lat=3",
                     i, w, ga, ge, gr, lat, ex[9], ex[8], ex[7:0]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_fill_overflow();
      test_back_to_back();
      test_random_async();
      test_wait_states();
      test_reset_mid();
      test_random_wait();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/wb_modport_device.md
# wb_modport_device

Wishbone B4 classic single-transfer device with a built-in FIFO. It is the device-side endpoint of the team's `wishbone_classic` interface, connected through its `device` modport. Writes push data, reads pop data, and overflow or underflow is reported with `err`. Wait states are configurable, so one block exercises both async-ack and sync-ack cycles.

## Interface
- `DAT_WIDTH`, default 8: data bus width.
- `DEPTH`, default 4: number of FIFO entries; must be ≥2.
- `WAIT_STATES`, default 0: cycles from request to response, 0..15. A value of 0 selects combinational (async) ack.
- `clk_i` input, 1 bit: the single clock; all logic on the rising edge.
- `rst_i` input, 1 bit: synchronous, active-high reset.
- `cyc_i` input, 1 bit: bus cycle valid.
- `stb_i` input, 1 bit: strobe.
- `we_i` input, 1 bit: 1 = write (push), 0 = read (pop).
- `dat_i` input, `DAT_WIDTH` bits: write data.
- `ack_o` output, 1 bit: successful termination.
- `err_o` output, 1 bit: error termination.
- `rty_o` output, 1 bit: retry; tied to 0.
- `dat_o` output, `DAT_WIDTH` bits: read data.

## Operation
- A request is `cyc_i && stb_i`. Exactly one of `ack_o` or `err_o` terminates each request.
- A response is `ack_o || err_o || rty_o`.
- **Write:**
  - FIFO not full: `ack_o` is asserted. `dat_i` is pushed at the clock edge that ends the response cycle.
  - FIFO full: `err_o` is asserted and the FIFO is unchanged.
- **Read:**
  - FIFO not empty: `ack_o` is asserted and `dat_o` carries the head entry during the response cycle. The head is popped at the clock edge that ends the response cycle.
  - FIFO empty: `err_o` is asserted and `dat_o` is 0.
- Outside a read response, `dat_o` is 0.
- **Storage:**
  - Circular buffer with read and write pointers that wrap from `DEPTH-1` to 0.
  - Occupancy counter width is `$clog2(DEPTH+1)`. Full means count == `DEPTH`; empty means count == 0.
- The full/empty decision is taken from the FIFO state in the response cycle.
- `we_i` and `dat_i` are sampled in the response cycle. The controller holds them stable, per protocol.
- Only one transfer is in flight at a time, so a push and a pop never occur in the same cycle.
- **State machine (used only when `WAIT_STATES` > 0):**
  - IDLE → WAIT when a request is seen; the wait counter is loaded with 1.
  - WAIT increments the counter on each cycle the request stays high.
  - WAIT → RESP when the counter reaches `WAIT_STATES`.
  - RESP drives the response for exactly one cycle, then returns to IDLE.
- **Aborted request:** if the request drops before the response, the FSM returns to IDLE with no FIFO change and no response. This is a controller protocol violation, tolerated without error.

## Timing
- Reset (`rst_i` high at an edge):
  - `ack_o`, `err_o`, `rty_o` = 0 and `dat_o` = 0.
  - FIFO emptied, pointers = 0, FSM in IDLE.
  - Any in-flight request is dropped with no response.
  - Reset dominates a simultaneous request.
- **`WAIT_STATES` = 0:**
  - The response is combinational from the request and the FIFO state: it appears in the same cycle the request rises.
  - Every cycle with the request high is a complete transfer. Holding `cyc_i`/`stb_i` high performs back-to-back transfers, one per clock.
- **`WAIT_STATES` = N > 0:**
  - If the request first appears in cycle T, the response is registered and asserted in cycle T+N.
  - The response lasts exactly one cycle.
  - The response is never asserted in a cycle where the request is low.
- **Back-to-back:** if the request stays high in the cycle after a response, that cycle starts a new transfer, and its response comes N cycles later.
- Every request is answered within `WAIT_STATES` cycles as long as it is held. This satisfies the property "request eventually followed by response".
- A request falls only after a response cycle.

## Test plan
1. **Reset behaviour.** Assert reset for 2 cycles, then hold idle for 10 cycles. Required: all outputs 0, no response.
2. **Write then read, `WAIT_STATES` = 0, `DEPTH` = 4.**
   - Write 0xA5 → `ack_o` in the same cycle.
   - Read → `ack_o` in the same cycle, `dat_o` = 0xA5.
   - Next read → `err_o` = 1, `dat_o` = 0.
3. **Fill and overflow.**
   - Writes 0x01..0x04 → four acks.
   - Fifth write 0x05 → `err_o`.
   - Four reads return 0x01..0x04 in order, confirming pointer wrap.
4. **Wait states, `WAIT_STATES` = 3.**
   - A request rising at cycle T → single-cycle `ack_o` at T+3, none at T+1 or T+2.
   - Holding the request high afterwards → next ack at T+7.
5. **Back-to-back async.** `WAIT_STATES` = 0, `cyc_i`/`stb_i` held high with writes 0x10, 0x11, 0x12 on consecutive clocks. Required: three acks, and reads return 0x10, 0x11, 0x12.
6. **Reset mid-transfer.** `WAIT_STATES` = 3, assert `rst_i` at T+1 during a write. Required: no ack, FIFO empty, and a subsequent read gives `err_o`.
